// File: rtl/cla_pipe.sv
// ============================================================================
// Module   : cla_pipe
// Purpose  : Pipelined carry-lookahead adder/subtractor. The operand is cut
//            into STAGES equal segments; segment k is resolved in pipeline
//            stage k from 4-bit CLA groups joined by a group-lookahead unit.
//            Upper operand bits are skewed forward and finished sum bits
//            ride along so a whole result leaves the last stage at once.
// Options  : define CLA_PIPE_OVF_EN to build signed-overflow detection;
//            otherwise ovf_o is tied low and no overflow logic exists.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cla_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             ci_i,
  input  logic             mode_i,
  output logic [WIDTH-1:0] s_cla_o,
  output logic             co_cla_o,
  output logic             ovf_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int NGRP = SEG / 4;

  // Bit-level lookahead across one 4-bit group; c[0] is the group carry-in.
  function automatic logic [4:0] cla4(input logic [3:0] g, input logic [3:0] p,
                                      input logic c0);
    logic [4:0] c;
    logic       acc;
    logic       pp;
    c[0] = c0;
    for (int i = 0; i < 4; i++) begin
      acc = g[i];
      pp  = p[i];
      for (int m = i - 1; m >= 0; m--) begin
        acc = acc | (pp & g[m]);
        pp  = pp & p[m];
      end
      c[i+1] = acc | (pp & c0);
    end
    return c;
  endfunction

  // Group-level lookahead: carry into every group of a segment at once.
  function automatic logic [NGRP:0] grp_look(input logic [NGRP-1:0] g,
                                             input logic [NGRP-1:0] p,
                                             input logic c0);
    logic [NGRP:0] c;
    logic          acc;
    logic          pp;
    c[0] = c0;
    for (int i = 0; i < NGRP; i++) begin
      acc = g[i];
      pp  = p[i];
      for (int m = i - 1; m >= 0; m--) begin
        acc = acc | (pp & g[m]);
        pp  = pp & p[m];
      end
      c[i+1] = acc | (pp & c0);
    end
    return c;
  endfunction

  logic              adv;
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] carry_q;
  logic [STAGES-1:0] carry_d;
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic [WIDTH-1:0]  stg_a [STAGES];
  logic [WIDTH-1:0]  stg_b [STAGES];
  logic [WIDTH-1:0]  stg_sum [STAGES];
  logic [STAGES-1:0] stg_c;
`ifdef CLA_PIPE_OVF_EN
  logic              ovf_d;
  logic              ovf_q;
`endif

  // The whole pipeline moves together: it advances whenever the output
  // register is empty or being consumed.
  assign adv        = out_ready_i | ~out_valid_o;
  assign in_ready_o = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SEG-1:0]   seg_a;
    logic [SEG-1:0]   seg_b;
    logic [SEG-1:0]   gen;
    logic [SEG-1:0]   prop;
    logic [SEG-1:0]   seg_sum;
    logic [SEG:0]     c;
    logic [NGRP-1:0]  grp_g;
    logic [NGRP-1:0]  grp_p;
    logic [NGRP:0]    grp_c;
    logic [4:0]       t;
    logic [WIDTH-1:0] sum_nx;

    if (k == 0) begin : g_first
      // Subtraction is a + ~b + 1, so invert b and force the carry-in.
      assign stg_a[k]   = a_i;
      assign stg_b[k]   = mode_i ? ~b_i : b_i;
      assign stg_c[k]   = mode_i | ci_i;
      assign stg_sum[k] = '0;
    end else begin : g_next
      assign stg_a[k]   = a_q[k-1];
      assign stg_b[k]   = b_q[k-1];
      assign stg_c[k]   = carry_q[k-1];
      assign stg_sum[k] = sum_q[k-1];
    end

    // Resolve segment k: group G/P, group lookahead, then in-group carries.
    always_comb begin
      seg_a = stg_a[k][k*SEG +: SEG];
      seg_b = stg_b[k][k*SEG +: SEG];
      gen   = seg_a & seg_b;
      prop  = seg_a ^ seg_b;
      t     = '0;
      grp_g = '0;
      grp_p = '0;
      c     = '0;
      for (int j = 0; j < NGRP; j++) begin
        t        = cla4(gen[4*j +: 4], prop[4*j +: 4], 1'b0);
        grp_g[j] = t[4];
        grp_p[j] = &prop[4*j +: 4];
      end
      grp_c = grp_look(grp_g, grp_p, stg_c[k]);
      for (int j = 0; j < NGRP; j++) begin
        t            = cla4(gen[4*j +: 4], prop[4*j +: 4], grp_c[j]);
        c[4*j +: 4]  = t[3:0];
      end
      c[SEG]  = grp_c[NGRP];
      seg_sum = prop ^ c[SEG-1:0];
      sum_nx  = stg_sum[k];
      sum_nx[k*SEG +: SEG] = seg_sum;
    end

    assign sum_d[k]   = sum_nx;
    assign carry_d[k] = c[SEG];

`ifdef CLA_PIPE_OVF_EN
    if (k == STAGES - 1) begin : g_ovf
      // Signed overflow: carry into the MSB differs from carry out of it.
      assign ovf_d = c[SEG] ^ c[SEG-1];
    end
`endif
  end

  // Stage registers: shift on advance, hold on stall, clear valids on reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      carry_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        sum_q[k] <= '0;
      end
    end else if (adv) begin
      valid_q[0] <= in_valid_i;
      for (int k = 1; k < STAGES; k++) begin
        valid_q[k] <= valid_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
        sum_q[k]   <= sum_d[k];
        carry_q[k] <= carry_d[k];
        a_q[k]     <= stg_a[k];
        b_q[k]     <= stg_b[k];
      end
    end
  end

`ifdef CLA_PIPE_OVF_EN
  // Overflow flag lives in the output rank alongside the final sum.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_q <= 1'b0;
    end else if (adv) begin
      ovf_q <= ovf_d;
    end
  end
  assign ovf_o = ovf_q;
`else
  assign ovf_o = 1'b0;
`endif

  assign s_cla_o     = sum_q[STAGES-1];
  assign co_cla_o    = carry_q[STAGES-1];
  assign out_valid_o = valid_q[STAGES-1];

endmodule

`default_nettype wire

// File: tb/tb_cla_pipe.sv
// ============================================================================
// Module   : tb_cla_pipe
// Purpose  : Scoreboard bench for cla_pipe. Three instances (32/2, 16/1,
//            16/4) share one stimulus stream; each keeps its own queue of
//            expected results and a monitor that checks data, latency,
//            stall stability and reset behaviour.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cla_pipe;

  typedef struct packed {
    logic        ovf;
    logic        co;
    logic [31:0] s;
  } exp_t;

  typedef struct {
    exp_t e;
    int   t;
    int   st;
  } item_t;

  logic        clk       = 1'b0;
  logic        rst       = 1'b1;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] a         = '0;
  logic [31:0] b         = '0;
  logic        ci        = 1'b0;
  logic        mode      = 1'b0;
  logic        rst_seen  = 1'b0;
  logic        end_chk   = 1'b0;
  int          cyc       = 0;
  int          n_vec     = 0;
  int          n_err     = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  // Reference: arithmetic on integers, signed range test for overflow.
  function automatic exp_t ref_model(input int w, input logic [31:0] fa,
                                     input logic [31:0] fb, input logic fci,
                                     input logic fmode);
    exp_t   r;
    longint full, half, ua, ub, tot, sa, sb, sr;
    full = longint'(1) << w;
    half = full >> 1;
    ua   = longint'({32'd0, fa}) & (full - 1);
    ub   = longint'({32'd0, fb}) & (full - 1);
    if (!fmode) begin
      tot  = ua + ub + longint'(fci);
      r.s  = 32'(tot & (full - 1));
      r.co = ((tot >> w) & 1) != 0;
    end else begin
      r.s  = 32'((ua - ub) & (full - 1));
      r.co = (ua >= ub);
    end
    sa = (ua >= half) ? ua - full : ua;
    sb = (ub >= half) ? ub - full : ub;
    sr = fmode ? (sa - sb) : (sa + sb + longint'(fci));
`ifdef CLA_PIPE_OVF_EN
    r.ovf = (sr >= half) || (sr < -half);
`else
    r.ovf = 1'b0;
`endif
    return r;
  endfunction

  for (genvar i = 0; i < 3; i++) begin : g_cfg
    localparam int W = (i == 0) ? 32 : 16;
    localparam int S = (i == 0) ? 2 : ((i == 1) ? 1 : 4);

    logic         in_ready, out_valid, co, ovf;
    logic [W-1:0] s;
    item_t        q[$];
    item_t        it;
    item_t        nit;
    int           stalls     = 0;
    logic         stall_prev = 1'b0;
    logic [W-1:0] held_s     = '0;
    logic         held_co    = 1'b0;
    logic         held_ovf   = 1'b0;
    exp_t         got;

    cla_pipe #(.WIDTH(W), .STAGES(S)) u_dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .in_valid_i (in_valid),
      .in_ready_o (in_ready),
      .a_i        (a[W-1:0]),
      .b_i        (b[W-1:0]),
      .ci_i       (ci),
      .mode_i     (mode),
      .s_cla_o    (s),
      .co_cla_o   (co),
      .ovf_o      (ovf),
      .out_valid_o(out_valid),
      .out_ready_i(out_ready)
    );

    // Stimulus side: record the expected result of every accepted operand.
    always @(negedge clk) begin
      if (!rst && in_valid && in_ready) begin
        nit.e  = ref_model(W, a, b, ci, mode);
        nit.t  = cyc;
        nit.st = stalls;
        q.push_back(nit);
      end
    end

    // Monitor side: compare whatever the DUT presents.
    always @(negedge clk) begin
      if (rst_seen) begin
        n_vec++;
        if (out_valid !== 1'b0 || s !== '0 || co !== 1'b0 || ovf !== 1'b0 || in_ready !== 1'b1) begin
          n_err++;
          $display("FAIL cfg%0d reset_state: got v=%b s=%h co=%b ovf=%b rdy=%b, want v=0 s=0 co=0 ovf=0 rdy=1",
                   i, out_valid, s, co, ovf, in_ready);
        end
      end
      if (stall_prev) begin
        n_vec++;
        if (out_valid !== 1'b1 || s !== held_s || co !== held_co || ovf !== held_ovf) begin
          n_err++;
          $display("FAIL cfg%0d stall_hold: got v=%b s=%h co=%b ovf=%b, want v=1 s=%h co=%b ovf=%b",
                   i, out_valid, s, co, ovf, held_s, held_co, held_ovf);
        end
      end
      if (rst) begin
        q.delete();
        stall_prev = 1'b0;
      end else begin
        stall_prev = 1'b0;
        if (out_valid === 1'b1) begin
          if (out_ready) begin
            n_vec++;
            if (q.size() == 0) begin
              n_err++;
              $display("FAIL cfg%0d unexpected_out: got s=%h co=%b with no result pending", i, s, co);
            end else begin
              it  = q.pop_front();
              got = '{ovf: ovf, co: co, s: 32'(s)};
              if (got !== it.e) begin
                n_err++;
                $display("FAIL cfg%0d data: got s=%h co=%b ovf=%b, want s=%h co=%b ovf=%b",
                         i, got.s, got.co, got.ovf, it.e.s, it.e.co, it.e.ovf);
              end
              n_vec++;
              if (cyc != it.t + S + (stalls - it.st)) begin
                n_err++;
                $display("FAIL cfg%0d latency: got cycle %0d, want cycle %0d",
                         i, cyc, it.t + S + (stalls - it.st));
              end
            end
          end else begin
            n_vec++;
            if (in_ready !== 1'b0) begin
              n_err++;
              $display("FAIL cfg%0d stall_ready: got in_ready=%b, want 0", i, in_ready);
            end
            stall_prev = 1'b1;
            held_s     = s;
            held_co    = co;
            held_ovf   = ovf;
            stalls++;
          end
        end
      end
      if (end_chk) begin
        n_vec++;
        if (q.size() != 0) begin
          n_err++;
          $display("FAIL cfg%0d drain: got %0d results missing, want 0", i, q.size());
        end
      end
    end
  end

  task automatic send(input logic [31:0] ta, input logic [31:0] tb,
                      input logic tci, input logic tmode);
    in_valid = 1'b1;
    a        = ta;
    b        = tb;
    ci       = tci;
    mode     = tmode;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 8)
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h0000_0000;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'h0000_8000;
      5:       return 32'h0000_7FFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed vectors: carry across every boundary, back-to-back adds,
    // subtract with ignored carry-in, signed overflow.
    send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    send(32'h0000_FFFF, 32'hFFFF_0000, 1'b0, 1'b0);
    send(32'h135F_A562, 32'h3561_4642, 1'b0, 1'b0);
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    send(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
    send(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1);
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    idle(6);

    // Backpressure: hold out_ready low for three cycles with results waiting.
    send(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
    send(32'h3333_3333, 32'h4444_4444, 1'b1, 1'b0);
    send(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b1);
    out_ready = 1'b0;
    send(32'h5555_5555, 32'h6666_6666, 1'b0, 1'b0);
    send(32'h7777_7777, 32'h0000_0001, 1'b0, 1'b0);
    send(32'h9999_9999, 32'h1111_1111, 1'b0, 1'b1);
    out_ready = 1'b1;
    idle(8);

    // Reset with transactions in flight; they must never emerge.
    send(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0);
    send(32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0);
    rst = 1'b1;
    send(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 1'b0);
    rst = 1'b0;
    idle(8);

    // Randomised traffic with bubbles, backpressure and mixed modes.
    repeat (400) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      a         = pick();
      b         = pick();
      ci        = 1'($urandom);
      mode      = 1'($urandom);
      @(posedge clk);
      #1;
    end

    out_ready = 1'b1;
    idle(12);
    end_chk = 1'b1;
    @(posedge clk);
    #1;
    end_chk = 1'b0;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cla_pipe.md
CLA_PIPE -- requirements
Module: cla_pipe

Interface
REQ-001 Parameter WIDTH, default 32: operand and sum width in bits; SHALL be a multiple of 4*STAGES.
REQ-002 Parameter STAGES, default 2, legal 1..4: number of pipeline segments, which SHALL equal the latency in cycles.
REQ-003 Ports SHALL be, in order: clock in 1 (system clock, rising edge); reset in 1 (synchronous, active-high); in_valid in 1 (operands present); in_ready out 1 (operands accepted this cycle); a in WIDTH (operand A); b in WIDTH (operand B); ci in 1 (carry-in, add mode only); mode in 1 (0=add, 1=subtract); s_cla out WIDTH (sum/difference); co_cla out 1 (carry-out); ovf out 1 (signed overflow); out_valid out 1 (result present); out_ready in 1 (downstream accepts result).
REQ-004 The block SHALL use one clock; reset SHALL be synchronous and active-high.

Function
REQ-005 Add mode SHALL produce {co_cla,s_cla} = a + b + ci, modulo 2^(WIDTH+1).
REQ-006 Subtract mode SHALL produce {co_cla,s_cla} = a + ~b + 1; ci SHALL be ignored; co_cla=1 SHALL mean no borrow.
REQ-007 The operand SHALL be split into STAGES equal segments; each segment SHALL be built from 4-bit carry-lookahead groups (generate/propagate plus group-lookahead), with no ripple chain spanning more than 4 bits.
REQ-008 Segment k SHALL be evaluated in pipeline stage k; its carry-out SHALL be registered and used as the carry-in of segment k+1 in stage k+1.
REQ-009 Operand bits of higher segments SHALL be skew-delayed; sum bits of lower segments SHALL be deskew-delayed so that all s_cla bits of one transaction appear together.
REQ-010 Global advance signal: adv = out_ready OR NOT out_valid; in_ready SHALL equal adv, combinationally.
REQ-011 A transaction SHALL be accepted when in_valid AND in_ready; when adv=1, every stage register (including valid bits) SHALL shift; when adv=0, all stage registers SHALL hold.
REQ-012 Latency: a transaction accepted at edge N SHALL present out_valid=1 with its result after edge N+STAGES-1, assuming no stall; each stall cycle SHALL add exactly one cycle.
REQ-013 With out_valid=1 and out_ready=0, s_cla, co_cla, ovf and out_valid SHALL remain stable.
REQ-014 Throughput SHALL be one result per cycle while in_valid=1 and out_ready=1; back-to-back transactions SHALL not interfere, including alternating mode values.
REQ-015 Bubbles (in_valid=0 while adv=1) SHALL propagate as out_valid=0 and SHALL not be collapsed.
REQ-016 When out_valid=0, s_cla, co_cla and ovf values SHALL be don't-care for the checker.
REQ-017 Operands of all-ones plus ci=1 SHALL carry through every segment boundary within the latency of REQ-012.

Reset
REQ-018 While reset=1 at a rising edge, all valid bits SHALL clear; s_cla=0, co_cla=0, ovf=0 and out_valid=0 SHALL hold from the next cycle.
REQ-019 Reset SHALL override in_valid and out_ready; in-flight transactions SHALL be discarded, not completed.
REQ-020 in_ready SHALL be 1 during and after reset, because out_valid=0; an input accepted in the same cycle reset is asserted SHALL be discarded.

Configuration
REQ-021 The macro CLA_PIPE_OVF_EN SHALL control overflow detection.
REQ-022 With CLA_PIPE_OVF_EN defined, ovf SHALL equal the carry into the MSB XOR the carry out of the MSB, pipelined alongside s_cla.
REQ-023 Without CLA_PIPE_OVF_EN, ovf SHALL be tied to 0 and no overflow logic or registers SHALL be present; the port list SHALL be unchanged.

Verification
REQ-024 Setup WIDTH=32, STAGES=2, add mode, a=FFFF_FFFF, b=0, ci=1 -> two cycles later, s_cla=0000_0000, co_cla=1, out_valid=1.
REQ-025 Three back-to-back add transactions -> s_cla/co_cla on consecutive cycles as follows:
  - a=0000_FFFF, b=FFFF_0000, ci=0 -> FFFF_FFFF, co_cla=0.
  - a=135F_A562, b=3561_4642, ci=0 -> 48C0_EBA4, co_cla=0.
  - a=FFFF_FFFF, b=0000_0001, ci=0 -> 0000_0000, co_cla=1.
REQ-026 Subtract mode, a=5, b=7, ci=1 -> s_cla=FFFF_FFFE, co_cla=0; a=7, b=5 -> s_cla=0000_0002, co_cla=1.
REQ-027 With the macro defined, add a=7FFF_FFFF, b=1 -> s_cla=8000_0000, ovf=1; without the macro -> ovf=0.
REQ-028 Hold out_ready=0 for 3 cycles while the result is valid -> outputs stable and in_ready=0; then release -> results drain in order with no loss or duplication.
REQ-029 Assert reset for one cycle with two transactions in flight -> out_valid=0 next cycle and neither result ever appears; repeat the sweep for STAGES=1 and STAGES=4 with WIDTH=16.
